pipe_stage_elastic: RTL and testbench

//   Generic, parametrised inter-stage pipeline register with valid/ready handshake,

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_slot.sv | 22 ++
 rtl/pipe_stage_elastic.sv | 152 +++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings for elastic pipeline stage registers.
// The occupancy state value doubles as the live-entry count.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_e;

  // RV32I "addi x0, x0, 0": bubble payload for instruction-carrying stages.
  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_slot.sv
// DATA_W-wide enable register with asynchronous active-low reset to a fixed value.
// Used as the head and skid storage of pipe_stage_elastic.
module pipe_slot #(
  parameter int                DATA_W  = 65,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Parametrised inter-stage pipeline register: valid/ready handshake, optional 2-entry
// skid buffer, synchronous flush to a bubble value and a saturating bubble counter.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both high;
// valid never depends on ready, and out_data is stable while out_valid && !out_ready.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 65,
  parameter bit                SKID       = 1'b1,
  parameter logic [DATA_W-1:0] FLUSH_DATA = '0,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  occ_e              state_q;
  occ_e              state_d;
  logic              accept;
  logic              pop;
  logic              head_en;
  logic [DATA_W-1:0] head_d;
  logic              skid_en;
  logic [DATA_W-1:0] skid_d;
  logic [DATA_W-1:0] skid_q;
  logic [CNT_W-1:0]  cnt_q;

  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = state_q;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Head is reloaded with FLUSH_DATA whenever it empties, so out_data never shows stale payload.
  always_comb begin
    state_d = state_q;
    head_en = 1'b0;
    head_d  = in_data;
    skid_en = 1'b0;
    skid_d  = in_data;
    if (flush) begin
      state_d = ST_EMPTY;
      head_en = 1'b1;
      head_d  = FLUSH_DATA;
      skid_en = 1'b1;
      skid_d  = FLUSH_DATA;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            head_en = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            head_en = 1'b1;
          end else if (accept && SKID) begin
            state_d = ST_FULL;
            skid_en = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
            head_en = 1'b1;
            head_d  = FLUSH_DATA;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d = ST_ONE;
            head_en = 1'b1;
            head_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          head_en = 1'b1;
          head_d  = FLUSH_DATA;
        end
      endcase
    end
  end

  pipe_slot #(
    .DATA_W  (DATA_W),
    .RST_VAL (FLUSH_DATA)
  ) u_head (
    .clk (clk),
    .rst (rst),
    .en  (head_en),
    .d   (head_d),
    .q   (out_data)
  );

  generate
    if (SKID) begin : g_skid
      logic ready_q;

      pipe_slot #(
        .DATA_W  (DATA_W),
        .RST_VAL (FLUSH_DATA)
      ) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (skid_d),
        .q   (skid_q)
      );

      // Registered ready breaks the out_ready -> in_ready timing path.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ready_q <= 1'b1;
        end else begin
          ready_q <= (state_d != ST_FULL);
        end
      end

      assign in_ready = ready_q;
    end else begin : g_noskid
      assign skid_q   = FLUSH_DATA;
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (!out_valid && !flush && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: a skid build (CNT_W=4) and a no-skid build, directed
// steps followed by random valid/ready traffic checked against expected-data queues.
module tb_pipe_stage_elastic;
  import pipe_pkg::*;

  localparam int          DW = 32;
  localparam logic [31:0] FD = NOP;

  logic          clk;
  logic          rst;

  logic          a_flush;
  logic          a_in_valid;
  logic          a_in_ready;
  logic [DW-1:0] a_in_data;
  logic          a_out_valid;
  logic          a_out_ready;
  logic [DW-1:0] a_out_data;
  logic [1:0]    a_occ;
  logic [3:0]    a_cnt;

  logic          b_flush;
  logic          b_in_valid;
  logic          b_in_ready;
  logic [DW-1:0] b_in_data;
  logic          b_out_valid;
  logic          b_out_ready;
  logic [DW-1:0] b_out_data;
  logic [1:0]    b_occ;
  logic [15:0]   b_cnt;

  logic [DW-1:0] a_q[$];
  logic [DW-1:0] b_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  pipe_stage_elastic #(
    .DATA_W (DW), .SKID (1'b1), .FLUSH_DATA (FD), .CNT_W (4)
  ) u_dut_skid (
    .clk (clk), .rst (rst), .flush (a_flush),
    .in_valid (a_in_valid), .in_ready (a_in_ready), .in_data (a_in_data),
    .out_valid (a_out_valid), .out_ready (a_out_ready), .out_data (a_out_data),
    .occupancy (a_occ), .bubble_cnt (a_cnt)
  );

  pipe_stage_elastic #(
    .DATA_W (DW), .SKID (1'b0), .FLUSH_DATA (FD), .CNT_W (16)
  ) u_dut_noskid (
    .clk (clk), .rst (rst), .flush (b_flush),
    .in_valid (b_in_valid), .in_ready (b_in_ready), .in_data (b_in_data),
    .out_valid (b_out_valid), .out_ready (b_out_ready), .out_data (b_out_data),
    .occupancy (b_occ), .bubble_cnt (b_cnt)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the skid build: model occupancy = queue depth, ready = depth < 2.
  always @(negedge clk) begin
    if (!rst) begin
      a_q.delete();
    end else begin
      check("a_occ_model", 64'(a_occ), 64'(a_q.size()));
      check("a_valid_model", 64'(a_out_valid), 64'(a_q.size() != 0));
      check("a_ready_model", 64'(a_in_ready), 64'(a_q.size() < 2));
      if (!a_out_valid) check("a_bubble_data", 64'(a_out_data), 64'(FD));
      if (a_flush) begin
        a_q.delete();
      end else begin
        if (a_out_valid && a_out_ready) begin
          check("a_pop_nonempty", 64'(a_q.size() != 0), 64'd1);
          if (a_q.size() != 0) check("a_order", 64'(a_out_data), 64'(a_q.pop_front()));
        end
        if (a_in_valid && a_in_ready) a_q.push_back(a_in_data);
      end
    end
  end

  // Scoreboard for the no-skid build: ready = empty or downstream consuming.
  always @(negedge clk) begin
    if (!rst) begin
      b_q.delete();
    end else begin
      check("b_occ_model", 64'(b_occ), 64'(b_q.size()));
      check("b_ready_model", 64'(b_in_ready), 64'((b_q.size() == 0) || b_out_ready));
      if (!b_out_valid) check("b_bubble_data", 64'(b_out_data), 64'(FD));
      if (b_flush) begin
        b_q.delete();
      end else begin
        if (b_out_valid && b_out_ready) begin
          check("b_pop_nonempty", 64'(b_q.size() != 0), 64'd1);
          if (b_q.size() != 0) check("b_order", 64'(b_out_data), 64'(b_q.pop_front()));
        end
        if (b_in_valid && b_in_ready) b_q.push_back(b_in_data);
      end
    end
  end

  initial begin
    rst = 1'b0;
    a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_out_data", 64'(a_out_data), 64'(FD));
    check("rst_occ", 64'(a_occ), 64'd0);
    check("rst_cnt", 64'(a_cnt), 64'd0);
    #2 rst = 1'b1;
    step();
    check("post_rst_in_ready", 64'(a_in_ready), 64'd1);
    check("post_rst_b_in_ready", 64'(b_in_ready), 64'd1);

    // Streaming 1..8 with one cycle latency
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 32'd1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check("stream_data", 64'(a_out_data), 64'(i));
      check("stream_occ", 64'(a_occ), 64'd1);
      check("stream_ready", 64'(a_in_ready), 64'd1);
      a_in_data = 32'(i + 1);
    end
    a_in_valid = 1'b0;
    step();
    check("stream_drain_valid", 64'(a_out_valid), 64'd0);
    check("stream_drain_data", 64'(a_out_data), 64'(FD));

    // Stall with A,B held, C waiting
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'hA0A0_0001;
    step();
    check("stall_occ1", 64'(a_occ), 64'd1);
    a_in_data = 32'hB0B0_0002;
    step();
    check("stall_occ2", 64'(a_occ), 64'd2);
    check("stall_ready0", 64'(a_in_ready), 64'd0);
    a_in_data = 32'hC0C0_0003;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold_data", 64'(a_out_data), 64'h0000_0000_A0A0_0001);
      check("stall_hold_occ", 64'(a_occ), 64'd2);
      check("stall_hold_ready", 64'(a_in_ready), 64'd0);
    end
    a_out_ready = 1'b1;
    step();
    check("release_b", 64'(a_out_data), 64'h0000_0000_B0B0_0002);
    check("release_occ", 64'(a_occ), 64'd1);
    check("release_ready", 64'(a_in_ready), 64'd1);
    step();
    check("release_c", 64'(a_out_data), 64'h0000_0000_C0C0_0003);
    a_in_valid = 1'b0;
    step();
    check("release_empty", 64'(a_occ), 64'd0);

    // Flush while FULL with a same-cycle input
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'hD0D0_0004;
    step();
    a_in_data = 32'hE0E0_0005;
    step();
    check("pre_flush_occ", 64'(a_occ), 64'd2);
    a_flush = 1'b1; a_in_data = 32'hF0F0_0006;
    step();
    a_flush = 1'b0; a_in_valid = 1'b0;
    check("flush_valid", 64'(a_out_valid), 64'd0);
    check("flush_data", 64'(a_out_data), 64'(FD));
    check("flush_occ", 64'(a_occ), 64'd0);
    check("flush_ready", 64'(a_in_ready), 64'd1);
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 32'h1234_5678;
    step();
    a_in_valid = 1'b0;
    check("post_flush_data", 64'(a_out_data), 64'h0000_0000_1234_5678);
    step();
    check("post_flush_empty", 64'(a_occ), 64'd0);

    // Asynchronous reset between edges while FULL
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'h0101_0101;
    step();
    a_in_data = 32'h0202_0202;
    step();
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 64'(a_out_valid), 64'd0);
    check("arst_data", 64'(a_out_data), 64'(FD));
    check("arst_occ", 64'(a_occ), 64'd0);
    check("arst_cnt", 64'(a_cnt), 64'd0);
    a_in_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    step();
    check("cnt_first", 64'(a_cnt), 64'd1);
    check("arst_ready", 64'(a_in_ready), 64'd1);

    // Bubble counter: frozen under flush, saturates at 15
    a_flush = 1'b1;
    step();
    step();
    a_flush = 1'b0;
    check("cnt_flush_hold", 64'(a_cnt), 64'd1);
    repeat (3) step();
    check("cnt_count", 64'(a_cnt), 64'd4);
    repeat (20) step();
    check("cnt_saturate", 64'(a_cnt), 64'd15);

    // No-skid build: combinational ready
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 32'h5555_0001;
    step();
    b_in_data = 32'h5555_0002;
    check("b_live", 64'(b_out_valid), 64'd1);
    check("b_ready_stall", 64'(b_in_ready), 64'd0);
    b_out_ready = 1'b1;
    #1;
    check("b_ready_comb", 64'(b_in_ready), 64'd1);
    step();
    b_in_valid = 1'b0;
    check("b_next", 64'(b_out_data), 64'h0000_0000_5555_0002);
    step();
    check("b_empty", 64'(b_occ), 64'd0);

    // Random traffic on both builds
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      #1;
      a_in_valid  = 1'($urandom_range(0, 1));
      a_out_ready = 1'($urandom_range(0, 1));
      a_in_data   = $urandom();
      a_flush     = ($urandom_range(0, 63) == 0);
      b_in_valid  = 1'($urandom_range(0, 1));
      b_out_ready = 1'($urandom_range(0, 1));
      b_in_data   = $urandom();
    end
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    repeat (4) step();
    check("a_drained", 64'(a_q.size()), 64'd0);
    check("b_drained", 64'(b_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
